// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural widths and the completion bundle
// carried from execute/memory towards the register-file write port.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } result_t;

endpackage

// File: rtl/writeback_scoreboard_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, set on issue,
// cleared on register-file write, with set taking priority on the same edge.
module writeback_scoreboard_scoreboard #(
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rd,
  input  logic                              issue_writes_rd,
  input  logic                              clear_en,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  clear_rd,
  output logic                              stall,
  output logic [NREG-1:0]                   busy_mask
);
  import riscv_pkg::*;

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            set_en;

  assign stall  = issue_valid & (busy_reg[issue_rs1] | busy_reg[issue_rs2] |
                                 (issue_writes_rd & busy_reg[issue_rd]));
  assign set_en = issue_valid & ~stall & issue_writes_rd;

  // x0 never has an outstanding writer, so its bit is tied off.
  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit       = set_en   && (issue_rd == REG_ADDR_W'(gi));
      assign clr_bit       = clear_en && (clear_rd == REG_ADDR_W'(gi));
      // A new writer issued on the clearing edge is still outstanding.
      assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign busy_mask = busy_reg;

endmodule

// File: rtl/writeback_scoreboard.sv
// Register-file write-port producer: load path has fixed priority over the
// ALU, the winner is registered onto the write port, scoreboard tracks rd.
module writeback_scoreboard #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rd,
  input  logic                              issue_writes_rd,
  output logic                              stall,
  input  logic                              alu_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  output logic                              alu_ready,
  input  logic                              mem_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]                   mem_data,
  output logic                              mem_ready,
  output logic [riscv_pkg::REG_ADDR_W-1:0]  rf_rd,
  output logic [XLEN-1:0]                   rf_write_data,
  output logic                              rf_write_enable,
  output logic [NREG-1:0]                   busy_mask
);
  import riscv_pkg::*;

  result_t               sel_result;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] rf_rd_reg;
  logic [XLEN-1:0]       rf_data_reg;
  logic                  rf_we_reg;

  assign mem_ready = 1'b1;
  assign alu_ready = ~mem_valid;

  always_comb begin
    sel_valid       = mem_valid | alu_valid;
    sel_result.rd   = alu_rd;
    sel_result.data = alu_data;
    if (mem_valid) begin
      sel_result.rd   = mem_rd;
      sel_result.data = mem_data;
    end
  end

  // Results to x0 are consumed (ready is still given) but never strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_rd_reg   <= '0;
      rf_data_reg <= '0;
      rf_we_reg   <= 1'b0;
    end else begin
      rf_we_reg <= sel_valid && (sel_result.rd != '0);
      if (sel_valid) begin
        rf_rd_reg   <= sel_result.rd;
        rf_data_reg <= sel_result.data;
      end
    end
  end

  assign rf_rd           = rf_rd_reg;
  assign rf_write_data   = rf_data_reg;
  assign rf_write_enable = rf_we_reg;

  writeback_scoreboard_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_rd        (issue_rd),
    .issue_writes_rd (issue_writes_rd),
    .clear_en        (rf_we_reg),
    .clear_rd        (rf_rd_reg),
    .stall           (stall),
    .busy_mask       (busy_mask)
  );

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Scoreboard bench: a reference model queues expected register-file writes
// and busy state; a negedge monitor compares everything the DUT presents.
module tb_writeback_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic        issue_writes_rd = 1'b0;
  logic        stall;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [31:0] busy_mask;

  writeback_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Reference model: set of outstanding registers plus a queue of writes
  // expected on the port in the cycle after each accepted completion.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_busy = '0;
  bit          m_wr_pending = 1'b0;
  logic [4:0]  m_wr_rd = '0;

  function automatic logic model_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                           (issue_writes_rd && m_busy[issue_rd]));
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [31:0] nb;
    exp_t        r;
    bit          have;
    if (reset) begin
      m_busy = '0;
      exp_q.delete();
      m_wr_pending = 1'b0;
    end else begin
      nb = m_busy;
      if (m_wr_pending) nb[m_wr_rd] = 1'b0;
      if (issue_valid && !model_stall() && issue_writes_rd && issue_rd != 0)
        nb[issue_rd] = 1'b1;
      have = 1'b1;
      if (mem_valid) begin r.rd = mem_rd; r.data = mem_data; end
      else if (alu_valid) begin r.rd = alu_rd; r.data = alu_data; end
      else have = 1'b0;
      m_wr_pending = 1'b0;
      if (have && r.rd != 0) begin
        exp_q.push_back(r);
        m_wr_pending = 1'b1;
        m_wr_rd = r.rd;
      end
      m_busy = nb;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      chk("reset_we", {31'd0, rf_write_enable}, 32'd0);
      chk("reset_rd", {27'd0, rf_rd}, 32'd0);
      chk("reset_data", rf_write_data, 32'd0);
      chk("reset_busy", busy_mask, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
    end else begin
      chk("stall", {31'd0, stall}, {31'd0, model_stall()});
      chk("busy_mask", busy_mask, m_busy);
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, !mem_valid});
      chk("mem_ready", {31'd0, mem_ready}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_we", {31'd0, rf_write_enable}, 32'd1);
        chk("write_rd", {27'd0, rf_rd}, {27'd0, e.rd});
        chk("write_data", rf_write_data, e.data);
        $display("write rd=%0d data=%08h", rf_rd, rf_write_data);
      end else begin
        chk("idle_we", {31'd0, rf_write_enable}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_writes_rd = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_rd = rd; issue_writes_rd = wr;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (2) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_alu_ready", {31'd0, alu_ready}, 32'd1);

    // RAW on rd=5 held until the ALU write lands
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("raw_stall", {31'd0, stall}, 32'd1);
    chk("raw_busy", busy_mask, 32'h0000_0020);
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_stall_on_completion", {31'd0, stall}, 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("raw_write_rd", {27'd0, rf_rd}, 32'd5);
    chk("raw_write_data", rf_write_data, 32'hDEAD_BEEF);
    chk("raw_stall_during_write", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("raw_stall_released", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();

    // simultaneous completions: load first, ALU the cycle after
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    @(negedge clk);
    chk("arb_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("arb_first_rd", {27'd0, rf_rd}, 32'd4);
    chk("arb_first_data", rf_write_data, 32'h22);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("arb_second_rd", {27'd0, rf_rd}, 32'd3);
    chk("arb_second_data", rf_write_data, 32'h11);
    chk("arb_b2b_we", {31'd0, rf_write_enable}, 32'd1);
    tick();

    // completion to x0 is consumed without a write strobe
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("x0_no_we", {31'd0, rf_write_enable}, 32'd0);
    chk("x0_busy0", {31'd0, busy_mask[0]}, 32'd0);
    tick();

    // issue rd=7 on the edge its stale write clears it: set wins
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    chk("sameedge_we", {31'd0, rf_write_enable}, 32'd1);
    chk("sameedge_issue_ok", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("sameedge_busy7", {31'd0, busy_mask[7]}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    tick();
    alu_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sameedge_cleared", {31'd0, busy_mask[7]}, 32'd0);
    tick();

    // asynchronous reset with registers busy and a write on the port
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    chk("prereset_busy", busy_mask, 32'h0000_00A0);
    chk("prereset_we", {31'd0, rf_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_we", {31'd0, rf_write_enable}, 32'd0);
    chk("async_rd", {27'd0, rf_rd}, 32'd0);
    chk("async_data", rf_write_data, 32'd0);
    chk("async_busy", busy_mask, 32'd0);
    chk("async_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    chk("postreset_busy", busy_mask, 32'd0);

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 300; i++) begin
      issue_valid     = ($urandom_range(0, 1) == 1);
      issue_rs1       = 5'($urandom_range(0, 7));
      issue_rs2       = 5'($urandom_range(0, 7));
      issue_rd        = 5'($urandom_range(0, 7));
      issue_writes_rd = ($urandom_range(0, 3) != 0);
      alu_valid       = ($urandom_range(0, 1) == 1);
      alu_rd          = 5'($urandom_range(0, 7));
      alu_data        = $urandom;
      mem_valid       = ($urandom_range(0, 3) == 0);
      mem_rd          = 5'($urandom_range(0, 7));
      mem_data        = $urandom;
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_scoreboard.md
# writeback_scoreboard

Producer side of the register file's write port: arbitrates completed results from the ALU and the load path onto the single write port (rd / write_data / write enable) and tracks pending destination registers in a scoreboard. The decode stage checks this scoreboard to stall on read-after-write and write-after-write hazards. It sits between execute/memory completion and the register file, next to decode.

## Interface
Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers. Register address width is log2(NREG) = 5.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  5  source registers of the presented instruction.
- issue_rd  in  5  destination register of the presented instruction.
- issue_writes_rd  in  1  the instruction writes rd.
- stall  out  1  combinational; issue must not be accepted this cycle.
- alu_valid  in  1  ALU result available.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  combinational; ALU result accepted.
- mem_valid  in  1  load data available.
- mem_rd  in  5  load destination register.
- mem_data  in  XLEN  load data.
- mem_ready  out  1  constant 1.
- rf_rd  out  5  register-file write address (registered).
- rf_write_data  out  XLEN  register-file write data (registered).
- rf_write_enable  out  1  register-file write strobe (registered).
- busy_mask  out  NREG  scoreboard state; bit 0 is always 0.

## Operation
- Scoreboard: busy[NREG-1:0]. Bit 0 is hardwired to 0.
- stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | (issue_writes_rd & busy[issue_rd])).
- An issue is accepted when issue_valid & !stall. If issue_writes_rd and issue_rd != 0, busy[issue_rd] is set at the next edge.
- Arbitration: the load path has fixed priority.
  - mem_ready = 1.
  - alu_ready = !mem_valid.
  - The selected source is mem when mem_valid, otherwise alu when alu_valid.
- The selected result is registered into rf_rd / rf_write_data. rf_write_enable = 1 only if the selected rd != 0. An rd == 0 result is consumed and dropped.
- Busy clear: at the edge where rf_write_enable = 1, busy[rf_rd] is cleared.
- Same-edge set and clear on one index: set wins, because the new writer is still outstanding.
- A completion to a register that is not busy is still written. The scoreboard is unchanged apart from the normal clear.
- Reset sets busy to 0, rf_write_enable to 0, rf_rd to 0 and rf_write_data to 0. In-flight results are discarded.

## Timing
- Result handshake accepted at edge N: rf_write_enable is high for exactly one cycle after edge N, and the register file writes at edge N+1.
- busy clears at edge N+1, so stall for that register drops in the cycle after N+1. Because the register file reads synchronously, a read issued then returns the new value. Bypass is never required.
- Issue at edge N: busy is visible at N+1. An issue presented in the same cycle as a completion for its source still stalls.
- Back-to-back completions sustain one write per cycle. rf_write_enable stays high across consecutive cycles with new rd/data each cycle.
- Asynchronous reset mid-operation forces all outputs to 0 immediately. stall is 0 during reset because busy is 0.

## Structure
- The shared package riscv_pkg holds:
  - XLEN and REG_ADDR_W = 5.
  - NREG.
  - the result-bundle struct {rd, data}.
- One sub-module is natural: scoreboard. It holds the busy vector, set/clear logic with set-priority, and the hazard compare producing stall.
- Arbitration and the output register stay in the top level.

## Test plan
- Reset, then idle: rf_write_enable = 0, busy_mask = 0, stall = 0, alu_ready = 1.
- Issue rd = 5 accepted, then issue rs1 = 5:
  - stall = 1 until the ALU completes rd = 5 with 0xDEADBEEF.
  - rf_write_enable pulses once with rf_rd = 5 and data 0xDEADBEEF.
  - stall drops the following cycle.
- Simultaneous alu_valid (rd = 3, 0x11) and mem_valid (rd = 4, 0x22):
  - cycle 1 writes rd = 4 / 0x22 with alu_ready = 0.
  - cycle 2 writes rd = 3 / 0x11.
- Completion to rd = 0 (data 0xFFFFFFFF): accepted, rf_write_enable stays 0, busy_mask[0] = 0.
- Issue of rd = 7 on the same edge as a rd = 7 completion write: busy_mask[7] = 1 afterward. A second completion clears it.
- Assert reset while busy_mask = 0x0000_00A0 and rf_write_enable = 1: all outputs go to 0 asynchronously, and no write occurs after release.
